// File: rtl/thresh_cfg_pkg.sv
// thresh_cfg_pkg: shared types and defaults
// for the threshold load controller.
package thresh_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    COMMIT,
    RELEASE
  } state_t;

  typedef enum logic {
    TGT_TEMP,
    TGT_LIGHT
  } target_t;

  localparam logic [7:0] DEF_TEMP_THRESH  = 8'd30;
  localparam logic [7:0] DEF_LIGHT_THRESH = 8'd100;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus
// counter debouncer with rise pulse.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic        s1;
  logic        s2;
  logic [15:0] cnt;

  // Sync the raw input; flip level after N disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= 16'd0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= 16'd0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        cnt   <= 16'd0;
        level <= s2;
        rise  <= s2;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/threshold_load_ctrl.sv
// threshold_load_ctrl: debounced, arbitrated,
// range-checked one-shot threshold writes.
module threshold_load_ctrl
  import thresh_cfg_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  TEMP_MAX        = 8'd80,
  parameter logic [7:0]  LIGHT_MIN       = 8'd10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_temp_raw,
  input  logic       btn_light_raw,
  input  logic [7:0] switch_input,
  output logic       load_temp,
  output logic       load_light,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err_range
);

  logic    t_lvl;
  logic    t_rise;
  logic    l_lvl;
  logic    l_rise;
  state_t  state_q;
  state_t  state_d;
  target_t tgt_q;
  logic [7:0] hold_q;
  logic    err_q;
  logic    legal;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_temp (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (btn_temp_raw),
    .level  (t_lvl),
    .rise   (t_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_light (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (btn_light_raw),
    .level  (l_lvl),
    .rise   (l_rise)
  );

  assign legal = (tgt_q == TGT_TEMP)
               ? (hold_q <= TEMP_MAX)
               : (hold_q >= LIGHT_MIN);

  // Next-state logic for the press sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (t_rise || l_rise) state_d = CAPTURE;
      CAPTURE: state_d = CHECK;
      CHECK:   state_d = legal ? COMMIT : RELEASE;
      COMMIT:  state_d = RELEASE;
      RELEASE: if (!t_lvl && !l_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, target, held value and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tgt_q   <= TGT_TEMP;
      hold_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (t_rise || l_rise))
        tgt_q <= t_rise ? TGT_TEMP : TGT_LIGHT;
      if (state_q == CAPTURE)
        hold_q <= switch_input;
      if (state_q == CHECK)
        err_q <= !legal;
    end
  end

  assign load_temp  = (state_q == COMMIT)
                   && (tgt_q == TGT_TEMP);
  assign load_light = (state_q == COMMIT)
                   && (tgt_q == TGT_LIGHT);
  assign wr_data    = hold_q;
  assign busy       = (state_q != IDLE);
  assign err_range  = err_q;

endmodule

// File: tb/tb_threshold_load_ctrl.sv
// tb_threshold_load_ctrl: scenario tasks plus
// randomized presses against a rule model.
module tb_threshold_load_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bt = 1'b0;
  logic       bl = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       load_temp;
  logic       load_light;
  logic [7:0] wr_data;
  logic       busy;
  logic       err_range;

  threshold_load_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .TEMP_MAX       (8'd80),
    .LIGHT_MIN      (8'd10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_temp_raw (bt),
    .btn_light_raw(bl),
    .switch_input (sw),
    .load_temp    (load_temp),
    .load_light   (load_light),
    .wr_data      (wr_data),
    .busy         (busy),
    .err_range    (err_range)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts = 0;
  int fails = 0;
  int nt, nl, nboth = 0;
  int tcyc, lcyc;
  logic [7:0] tdata, ldata;
  localparam int LAT = 2 + 4 + 3;

  function automatic bit model_legal(bit is_t, int v);
    if (is_t) return v <= 80;
    return v >= 10;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (load_temp) begin
        nt++; tdata = wr_data; tcyc = cyc;
      end
      if (load_light) begin
        nl++; ldata = wr_data; lcyc = cyc;
      end
      if (load_temp && load_light) nboth++;
    end
  endtask

  task automatic clr();
    nt = 0; nl = 0; tcyc = -1; lcyc = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    asserts++;
    if (load_temp !== 1'b0 || load_light !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: got %b%b expected 00",
               load_temp, load_light);
    end
    asserts++;
    if (wr_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_wr_data: got %0d expected 0", wr_data);
    end
    asserts++;
    if (busy !== 1'b0 || err_range !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_err: got %b%b expected 00",
               busy, err_range);
    end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_legal_temp();
    int c0;
    clr();
    sw = 8'd45; bt = 1'b1; c0 = cyc;
    step(15);
    asserts++;
    if (nt !== 1 || nl !== 0) begin
      fails++;
      $display("FAIL legal_temp_count: got t=%0d l=%0d expected 1 0",
               nt, nl);
    end
    asserts++;
    if (tcyc !== c0 + LAT) begin
      fails++;
      $display("FAIL legal_temp_latency: got %0d expected %0d",
               tcyc - c0, LAT);
    end
    asserts++;
    if (tdata !== 8'd45 || err_range !== 1'b0) begin
      fails++;
      $display("FAIL legal_temp_data: got %0d err=%b expected 45 0",
               tdata, err_range);
    end
    asserts++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL legal_temp_busy_held: got %b expected 1", busy);
    end
    bt = 1'b0;
    step(12);
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL legal_temp_busy_rel: got %b expected 0", busy);
    end
  endtask

  task automatic test_range();
    int c0;
    clr();
    sw = 8'd81; bt = 1'b1;
    step(15);
    asserts++;
    if (nt !== 0 || err_range !== 1'b1) begin
      fails++;
      $display("FAIL range_temp81: got t=%0d err=%b expected 0 1",
               nt, err_range);
    end
    bt = 1'b0; step(12);
    clr();
    sw = 8'd200; bl = 1'b1; c0 = cyc;
    step(15);
    asserts++;
    if (nl !== 1 || ldata !== 8'd200 || lcyc !== c0 + LAT) begin
      fails++;
      $display("FAIL range_light200: got n=%0d d=%0d lat=%0d expected 1 200 %0d",
               nl, ldata, lcyc - c0, LAT);
    end
    asserts++;
    if (err_range !== 1'b0) begin
      fails++;
      $display("FAIL range_err_clear: got %b expected 0", err_range);
    end
    bl = 1'b0; step(12);
  endtask

  task automatic test_bounce();
    clr();
    sw = 8'd55;
    repeat (10) begin
      bl = ~bl; step(2);
    end
    asserts++;
    if (nl !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bounce_toggle: got n=%0d busy=%b expected 0 0",
               nl, busy);
    end
    bl = 1'b1; step(15);
    asserts++;
    if (nl !== 1 || ldata !== 8'd55) begin
      fails++;
      $display("FAIL bounce_settle: got n=%0d d=%0d expected 1 55",
               nl, ldata);
    end
    bl = 1'b0; step(12);
    clr();
    bl = 1'b1; step(3);
    bl = 1'b0; step(15);
    asserts++;
    if (nl !== 0 || nt !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bounce_glitch: got n=%0d busy=%b expected 0 0",
               nl, busy);
    end
  endtask

  task automatic test_simultaneous();
    clr();
    sw = 8'd20; bt = 1'b1; bl = 1'b1;
    step(15);
    asserts++;
    if (nt !== 1 || nl !== 0 || tdata !== 8'd20) begin
      fails++;
      $display("FAIL simultaneous: got t=%0d l=%0d d=%0d expected 1 0 20",
               nt, nl, tdata);
    end
    bt = 1'b0; bl = 1'b0; step(12);
  endtask

  task automatic test_held();
    clr();
    sw = 8'd50; bt = 1'b1; step(15);
    bl = 1'b1; step(15);
    bt = 1'b0; step(15);
    asserts++;
    if (nt !== 1 || nl !== 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL held_block: got t=%0d l=%0d busy=%b expected 1 0 1",
               nt, nl, busy);
    end
    bl = 1'b0; step(12);
    asserts++;
    if (busy !== 1'b0 || nl !== 0) begin
      fails++;
      $display("FAIL held_release: got busy=%b l=%0d expected 0 0",
               busy, nl);
    end
    clr();
    sw = 8'd60; bl = 1'b1; step(15);
    asserts++;
    if (nl !== 1 || ldata !== 8'd60) begin
      fails++;
      $display("FAIL held_fresh: got n=%0d d=%0d expected 1 60",
               nl, ldata);
    end
    bl = 1'b0; step(12);
  endtask

  task automatic test_boundary();
    bit   tt [3] = '{1'b1, 1'b0, 1'b0};
    int   vv [3] = '{80, 10, 9};
    int   c0;
    bit   ok;
    for (int i = 0; i < 3; i++) begin
      clr();
      ok = model_legal(tt[i], vv[i]);
      sw = 8'(vv[i]);
      if (tt[i]) bt = 1'b1; else bl = 1'b1;
      step(15);
      asserts++;
      if ((tt[i] ? nt : nl) !== (ok ? 1 : 0) || nt + nl > 1
          || err_range !== !ok) begin
        fails++;
        $display("FAIL boundary_%0d: got t=%0d l=%0d err=%b expected ok=%b",
                 vv[i], nt, nl, err_range, ok);
      end
      bt = 1'b0; bl = 1'b0; step(12);
    end
    clr();
    sw = 8'd50; bt = 1'b1; c0 = cyc;
    step(8);
    sw = 8'd99;
    step(7);
    asserts++;
    if (nt !== 1 || tdata !== 8'd50 || tcyc !== c0 + LAT) begin
      fails++;
      $display("FAIL switch_in_check: got n=%0d d=%0d expected 1 50",
               nt, tdata);
    end
    bt = 1'b0; step(12);
  endtask

  task automatic test_reset_mid();
    int c1;
    clr();
    sw = 8'd33; bt = 1'b1;
    step(7);
    sw = 8'd33;
    step(1);
    reset_n = 1'b0;
    #1;
    asserts++;
    if (busy !== 1'b0 || load_temp !== 1'b0 || wr_data !== 8'h00
        || err_range !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_async: got busy=%b lt=%b d=%0d err=%b expected 0 0 0 0",
               busy, load_temp, wr_data, err_range);
    end
    step(3);
    reset_n = 1'b1; c1 = cyc;
    step(7);
    asserts++;
    if (nt !== 0) begin
      fails++;
      $display("FAIL reset_mid_early: got %0d strobes expected 0", nt);
    end
    step(8);
    asserts++;
    if (nt !== 1 || tcyc !== c1 + LAT || tdata !== 8'd33) begin
      fails++;
      $display("FAIL reset_mid_redebounce: got n=%0d lat=%0d expected 1 %0d",
               nt, tcyc - c1, LAT);
    end
    bt = 1'b0; step(12);
  endtask

  task automatic test_random();
    bit is_t;
    bit ok;
    int v;
    int c0;
    for (int i = 0; i < 12; i++) begin
      clr();
      is_t = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: v = int'($urandom_range(0, 255));
        1: v = int'($urandom_range(76, 85));
        default: v = int'($urandom_range(5, 14));
      endcase
      ok = model_legal(is_t, v);
      sw = 8'(v);
      if (is_t) bt = 1'b1; else bl = 1'b1;
      c0 = cyc;
      step(15);
      asserts++;
      if (ok) begin
        if ((is_t ? nt : nl) !== 1 || nt + nl !== 1
            || (is_t ? tdata : ldata) !== 8'(v)
            || (is_t ? tcyc : lcyc) !== c0 + LAT
            || err_range !== 1'b0) begin
          fails++;
          $display("FAIL random_%0d: t=%b v=%0d got t=%0d l=%0d err=%b expected one strobe err 0",
                   i, is_t, v, nt, nl, err_range);
        end
      end else begin
        if (nt + nl !== 0 || err_range !== 1'b1) begin
          fails++;
          $display("FAIL random_%0d: t=%b v=%0d got t=%0d l=%0d err=%b expected no strobe err 1",
                   i, is_t, v, nt, nl, err_range);
        end
      end
      bt = 1'b0; bl = 1'b0;
      step(12);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_legal_temp();
    test_range();
    test_bounce();
    test_simultaneous();
    test_held();
    test_boundary();
    test_reset_mid();
    test_random();
    asserts++;
    if (nboth !== 0) begin
      fails++;
      $display("FAIL strobe_exclusive: got %0d overlaps expected 0",
               nboth);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
